// File: rtl/bits_pkg.sv
// Shared widths and helpers for the variable-length bit packer.
package bits_pkg;

  localparam int unsigned OUT_W    = 32;
  localparam int unsigned IN_W     = 15;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned LENOUT_W = 6;
  localparam int unsigned COMB_W   = OUT_W + IN_W;

  // Low `len` bits set; len=0 gives an all-zero mask.
  function automatic logic [IN_W-1:0] frag_mask(input logic [LEN_W-1:0] len);
    logic [IN_W:0] w_m;
    w_m = ({{IN_W{1'b0}}, 1'b1} << len) - {{IN_W{1'b0}}, 1'b1};
    return w_m[IN_W-1:0];
  endfunction

endpackage

// File: rtl/bits_pack_merge.sv
// Combinational merge of a masked fragment into the accumulator at the fill point.
module bits_pack_merge
  import bits_pkg::*;
(
  input  logic [OUT_W-1:0]    i_acc,
  input  logic [CNT_W-1:0]    i_cnt,
  input  logic [IN_W-1:0]     i_datain,
  input  logic [LEN_W-1:0]    i_lenin,
  output logic [COMB_W-1:0]   o_comb,
  output logic [LENOUT_W-1:0] o_tot
);

  logic [IN_W-1:0] w_frag;

  assign w_frag = i_datain & frag_mask(i_lenin);
  assign o_comb = {{IN_W{1'b0}}, i_acc} | ({{OUT_W{1'b0}}, w_frag} << i_cnt);
  assign o_tot  = {2'b00, i_lenin} + {1'b0, i_cnt};

endmodule

// File: rtl/bits_pack.sv
// Bit packer top: accumulator/fill-count registers, deferred flush residual and scan chain.
module bits_pack
  import bits_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                pushin,
  input  logic [LEN_W-1:0]    lenin,
  input  logic [IN_W-1:0]     datain,
  input  logic                flushin,
  input  logic                scanEnable,
  input  logic                scanIn,
  output logic                scanOut,
  output logic                pushout,
  output logic [LENOUT_W-1:0] lenout,
  output logic [OUT_W-1:0]    dataout
);

  logic [OUT_W-1:0]    r_acc, w_acc_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic                r_flush_pend, w_flush_pend_d;
  logic                r_pushout, w_pushout_d;
  logic [LENOUT_W-1:0] r_lenout, w_lenout_d;
  logic [OUT_W-1:0]    r_dataout, w_dataout_d;

  logic [LEN_W-1:0]    w_len;
  logic [IN_W-1:0]     w_frag;
  logic [COMB_W-1:0]   w_comb;
  logic [LENOUT_W-1:0] w_tot;

  // An idle cycle behaves exactly like a zero-length push.
  assign w_len  = pushin ? lenin : '0;
  assign w_frag = datain & frag_mask(w_len);

  bits_pack_merge u_merge (
    .i_acc    (r_acc),
    .i_cnt    (r_cnt),
    .i_datain (datain),
    .i_lenin  (w_len),
    .o_comb   (w_comb),
    .o_tot    (w_tot)
  );

  always_comb begin
    w_acc_d        = r_acc;
    w_cnt_d        = r_cnt;
    w_flush_pend_d = r_flush_pend;
    w_pushout_d    = 1'b0;
    w_lenout_d     = r_lenout;
    w_dataout_d    = r_dataout;
    if (scanEnable) begin
      w_cnt_d = {r_cnt[CNT_W-2:0], scanIn};
    end else if (r_flush_pend) begin
      // Emit the residual left by last cycle's flush; the new fragment starts a fresh word.
      w_pushout_d    = 1'b1;
      w_dataout_d    = r_acc;
      w_lenout_d     = {1'b0, r_cnt};
      w_acc_d        = {{(OUT_W-IN_W){1'b0}}, w_frag};
      w_cnt_d        = {1'b0, w_len};
      w_flush_pend_d = flushin && (w_len != '0);
    end else if (w_tot[LENOUT_W-1]) begin
      // tot >= 32: low five bits of tot are the residual count.
      w_pushout_d    = 1'b1;
      w_dataout_d    = w_comb[OUT_W-1:0];
      w_lenout_d     = LENOUT_W'(OUT_W);
      w_acc_d        = {{(OUT_W-IN_W){1'b0}}, w_comb[COMB_W-1:OUT_W]};
      w_cnt_d        = w_tot[CNT_W-1:0];
      w_flush_pend_d = flushin && (w_tot[CNT_W-1:0] != '0);
    end else if (flushin && (w_tot != '0)) begin
      w_pushout_d = 1'b1;
      w_dataout_d = w_comb[OUT_W-1:0];
      w_lenout_d  = w_tot;
      w_acc_d     = '0;
      w_cnt_d     = '0;
    end else begin
      w_acc_d = w_comb[OUT_W-1:0];
      w_cnt_d = w_tot[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_pushout    <= 1'b0;
      r_lenout     <= '0;
      r_dataout    <= '0;
    end else begin
      r_acc        <= w_acc_d;
      r_cnt        <= w_cnt_d;
      r_flush_pend <= w_flush_pend_d;
      r_pushout    <= w_pushout_d;
      r_lenout     <= w_lenout_d;
      r_dataout    <= w_dataout_d;
    end
  end

  assign scanOut = scanEnable ? r_cnt[CNT_W-1] : 1'b0;
  assign pushout = r_pushout;
  assign lenout  = r_lenout;
  assign dataout = r_dataout;

endmodule

// File: tb/tb_bits_pack.sv
// Scoreboard bench for bits_pack: bit-queue reference model plus directed corner cases.
module tb_bits_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        pushin;
  logic [3:0]  lenin;
  logic [14:0] datain;
  logic        flushin;
  logic        scanEnable;
  logic        scanIn;
  logic        scanOut;
  logic        pushout;
  logic [5:0]  lenout;
  logic [31:0] dataout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          len;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   bq[$];

  always #5 clk = ~clk;

  bits_pack dut (
    .clk        (clk),
    .rst        (rst),
    .pushin     (pushin),
    .lenin      (lenin),
    .datain     (datain),
    .flushin    (flushin),
    .scanEnable (scanEnable),
    .scanIn     (scanIn),
    .scanOut    (scanOut),
    .pushout    (pushout),
    .lenout     (lenout),
    .dataout    (dataout)
  );

  // Reference: a plain stream of bits; words are cut every 32 bits, a flush cuts whatever remains.
  task automatic emit(input int k);
    exp_t e;
    e.len  = k;
    e.data = '0;
    for (int i = 0; i < k; i++) e.data[i] = bq.pop_front();
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic p, input logic [3:0] l, input logic [14:0] d,
                            input logic f);
    int n;
    n = p ? int'(l) : 0;
    for (int i = 0; i < n; i++) bq.push_back(d[i]);
    while (bq.size() >= 32) emit(32);
    if (f && bq.size() > 0) emit(bq.size());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic p, input logic [3:0] l, input logic [14:0] d, input logic f);
    pushin  = p;
    lenin   = l;
    datain  = d;
    flushin = f;
    model_step(p, l, d, f);
    tick();
    pushin  = 1'b0;
    flushin = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_out(input string name, input logic p, input logic [31:0] d, input int l);
    chk({name, "_pushout"}, {31'd0, pushout}, {31'd0, p});
    if (p) begin
      chk({name, "_dataout"}, dataout, d);
      chk({name, "_lenout"}, {26'd0, lenout}, l[31:0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    bq.delete();
  endtask

  // Monitor: every presented word must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && pushout === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data 0x%0h len %0d expected no output", dataout, lenout);
      end else begin
        e = exp_q.pop_front();
        if (dataout !== e.data || int'(lenout) != e.len) begin
          errors++;
          $display("FAIL sb_word: got data 0x%0h len %0d expected data 0x%0h len %0d",
                   dataout, lenout, e.data, e.len);
        end
      end
    end
  end

  initial begin
    logic [4:0] scnt;
    logic [4:0] sbits;
    rst        = 1'b1;
    pushin     = 1'b0;
    lenin      = '0;
    datain     = '0;
    flushin    = 1'b0;
    scanEnable = 1'b0;
    scanIn     = 1'b0;
    tick();
    tick();
    chk("reset_pushout", {31'd0, pushout}, 32'd0);
    chk("reset_dataout", dataout, 32'd0);
    chk("reset_lenout", {26'd0, lenout}, 32'd0);
    rst = 1'b0;

    // Byte packing
    cyc(1'b1, 4'd8, 15'h0AB, 1'b0);
    cyc(1'b1, 4'd8, 15'h0CD, 1'b0);
    cyc(1'b1, 4'd8, 15'h0EF, 1'b0);
    chk_out("bytes_partial", 1'b0, 32'd0, 0);
    cyc(1'b1, 4'd8, 15'h012, 1'b0);
    chk_out("bytes_word", 1'b1, 32'h12EFCDAB, 32);
    chk("bytes_cnt", {27'd0, dut.r_cnt}, 32'd0);

    // Masking and zero length
    cyc(1'b1, 4'd4, 15'h7FF5, 1'b0);
    cyc(1'b1, 4'd0, 15'h7FFF, 1'b0);
    chk_out("zero_len", 1'b0, 32'd0, 0);
    cyc(1'b0, 4'd0, 15'h0, 1'b1);
    chk_out("mask_flush", 1'b1, 32'h00000005, 4);

    // Flush that overflows a word
    cyc(1'b1, 4'd14, 15'h3FFF, 1'b0);
    cyc(1'b1, 4'd14, 15'h3FFF, 1'b0);
    chk("ovf_cnt28", {27'd0, dut.r_cnt}, 32'd28);
    cyc(1'b1, 4'd15, 15'h7FFF, 1'b1);
    chk_out("ovf_full", 1'b1, 32'hFFFFFFFF, 32);
    cyc(1'b1, 4'd3, 15'h5, 1'b0);
    chk_out("ovf_residual", 1'b1, 32'h000007FF, 11);
    chk("ovf_retained_cnt", {27'd0, dut.r_cnt}, 32'd3);
    cyc(1'b0, 4'd0, 15'h0, 1'b1);
    chk_out("ovf_retained_flush", 1'b1, 32'h00000005, 3);

    // Carry-over
    cyc(1'b1, 4'd15, 15'h7FFF, 1'b0);
    cyc(1'b1, 4'd15, 15'h7FFF, 1'b0);
    cyc(1'b1, 4'd15, 15'h7FFF, 1'b0);
    chk_out("carry_word", 1'b1, 32'hFFFFFFFF, 32);
    chk("carry_cnt", {27'd0, dut.r_cnt}, 32'd13);
    cyc(1'b0, 4'd0, 15'h0, 1'b1);
    chk_out("carry_flush", 1'b1, 32'h00001FFF, 13);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 15'($urandom),
          ($urandom_range(0, 7) == 0));
    end
    cyc(1'b0, 4'd0, 15'h0, 1'b1);
    cyc(1'b0, 4'd0, 15'h0, 1'b1);
    tick();
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);

    // Reset with a flush residual pending
    cyc(1'b1, 4'd14, 15'h3FFF, 1'b0);
    cyc(1'b1, 4'd14, 15'h3FFF, 1'b0);
    cyc(1'b1, 4'd14, 15'h2AAA, 1'b1);
    chk("rst_pend_set", {31'd0, dut.r_flush_pend}, 32'd1);
    @(negedge clk);
    #1;
    do_reset();
    chk("rst_mid_pushout", {31'd0, pushout}, 32'd0);
    chk("rst_mid_dataout", dataout, 32'd0);
    chk("rst_mid_lenout", {26'd0, lenout}, 32'd0);
    cyc(1'b0, 4'd0, 15'h0, 1'b1);
    chk("rst_then_flush", {31'd0, pushout}, 32'd0);

    // Scan chain: 1,0,1,1,0 into an empty count
    sbits      = 5'b10110;
    scnt       = 5'd0;
    scanEnable = 1'b1;
    pushin     = 1'b1;
    lenin      = 4'd15;
    datain     = 15'h7FFF;
    flushin    = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      scanIn = sbits[i];
      #1;
      chk("scan_out", {31'd0, scanOut}, {31'd0, scnt[4]});
      tick();
      scnt = {scnt[3:0], sbits[i]};
      chk("scan_no_push", {31'd0, pushout}, 32'd0);
    end
    chk("scan_cnt", {27'd0, dut.r_cnt}, {27'd0, scnt});
    chk("scan_out_last", {31'd0, scanOut}, {31'd0, scnt[4]});
    pushin     = 1'b0;
    flushin    = 1'b0;
    scanEnable = 1'b0;
    #1;
    chk("scan_off", {31'd0, scanOut}, 32'd0);
    do_reset();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
